// File: rtl/multi_button_pulser.sv
// N-channel pushbutton conditioner: synchronise, debounce and edge-detect each button, with
// optional hold-to-auto-repeat. `release` is a reserved word, so the release strobe is release_o.

module mbp_channel #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic rep_en,
  output logic level,
  output logic pulse,
  output logic release_o
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [RW-1:0] H_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic          s1_q, s1_d, s_q, s_d;
  logic          level_q, level_d, lvl_d1_q, lvl_d1_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pulse_q, pulse_d, release_q, release_d;
  logic          press, fall, rep_fire;

  always_comb begin
    s1_d     = btn;
    s_d      = s1_q;
    level_d  = level_q;
    dcnt_d   = dcnt_q;
    lvl_d1_d = level_q;
    if (s_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_LAST) begin
      level_d = s_q;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + D_ONE;
    end
  end

  assign press = level_q & ~lvl_d1_q;
  assign fall  = ~level_q & lvl_d1_q;

  // Level low is checked first so a release always beats a coincident repeat expiry.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rep_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_HOLD;
          rcnt_d  = '0;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!level_q) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end else if (!rep_en) begin
          state_d = ST_HOLD;
          rcnt_d  = '0;
        end else if (rcnt_q == ((state_q == ST_HOLD) ? H_LAST : R_LAST)) begin
          rep_fire = 1'b1;
          state_d  = ST_REPEAT;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
    endcase
    pulse_d   = press | rep_fire;
    release_d = fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s_q       <= 1'b0;
      level_q   <= 1'b0;
      lvl_d1_q  <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s_q       <= s_d;
      level_q   <= level_d;
      lvl_d1_q  <= lvl_d1_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign release_o = release_q;
endmodule

module multi_button_pulser #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] buttons,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] release_o
);
  mbp_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_ch [NUM_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .btn      (buttons),
    .rep_en   (repeat_en),
    .level    (level),
    .pulse    (pulse),
    .release_o(release_o)
  );
endmodule
